// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with clear-after-reset sequencer; optional write-to-read bypass via REGFILE_BYPASS_EN
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic                wr0_en_i,
  input  logic [AW-1:0]       wr0_addr_i,
  input  logic [XLEN-1:0]     wr0_data_i,
  input  logic                wr1_en_i,
  input  logic [AW-1:0]       wr1_addr_i,
  input  logic [XLEN-1:0]     wr1_data_i,
  output logic                ready_o
);
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [AW:0] LAST = (AW+1)'(NREG - 1);
  state_t state, state_n;
  logic [AW:0] cnt;
  logic [XLEN-1:0] mem [NREG];
  logic w0_ok, w1_ok;
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else state <= state_n;
  end
  always_comb state_n = (state == CLEAR && cnt == LAST) ? READY : state;
  always_comb ready_o = (state == READY);
  always_comb begin
    w0_ok = ready_o && wr0_en_i && !(ZERO_REG != 0 && wr0_addr_i == '0);
    w1_ok = ready_o && wr1_en_i && !(ZERO_REG != 0 && wr1_addr_i == '0);
  end
  // port 1 wins a same-address collision; port 0 is dropped entirely
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (!ready_o) begin
      mem[cnt[AW-1:0]] <= '0;
      cnt <= cnt + (AW+1)'(1);
    end else begin
      if (w0_ok && !(w1_ok && wr1_addr_i == wr0_addr_i)) mem[wr0_addr_i] <= wr0_data_i;
      if (w1_ok) mem[wr1_addr_i] <= wr1_data_i;
    end
  end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] v;
    assign a = rd_addr_i[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign v = (w1_ok && wr1_addr_i == a) ? wr1_data_i : (w0_ok && wr0_addr_i == a) ? wr0_data_i : mem[a];
`else
    assign v = mem[a];
`endif
    assign rd_data_o[p*XLEN +: XLEN] = (!ready_o || (ZERO_REG != 0 && a == '0)) ? '0 : v;
  end
endmodule
